load_access_unit: RTL and testbench
===================================

// Module: load_access_unit
// PURPOSE
//  Load-side counterpart of the store decoder/store path in the multicycle RV32 core.
//  - Accepts a load request (funct3, byte address) from the control FSM.
//  - Runs one word-aligned read handshake on the native memory bus.
//  - Aligns, then sign- or zero-extends the returned lane into a 32-bit result.
//  - Reports done or fault.
//  - amo_operation_load forces a word load, matching the AMO handling on the store side.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles spent in REQ without mem_ready before a bus-timeout fault (>=2)
// PORTS
//  clk                 in   1   core clock, rising edge
//  resetn              in   1   asynchronous active-low reset
//  start               in   1   load request pulse; accepted only when busy=0
//  funct3              in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  amo_operation_load  in   1   force LW semantics, ignoring funct3
//  addr                in   32  byte address of the load
//  busy                out  1   unit is not IDLE
//  done                out  1   one-cycle completion strobe
//  fault               out  1   qualifies done: access failed, result_data=0
//  fault_cause         out  2   00 none, 01 illegal funct3, 10 misaligned, 11 bus timeout
//  result_data         out  32  extended load result; held until next start
//  mem_valid           out  1   bus read request
//  mem_addr            out  32  {addr[31:2],2'b00}
//  mem_rstrb           out  4   byte lanes read: LB/LBU 0001<<a[1:0], LH/LHU 0011<<{a[1],0}, LW 1111
//  mem_ready           in   1   bus read data valid this cycle
//  mem_rdata           in   32  bus read data
// BEHAVIOUR
//  - Reset (async, resetn=0):
//    - All outputs 0; state=IDLE; timeout counter=0.
//    - Mid-transaction, mem_valid drops immediately; no done is produced.
//  - States: IDLE, REQ, RESP.
//  - IDLE, start=1: latch funct3/addr/amo; decode the access.
//    - Illegal funct3 (011, 110, 111; amo=0): go to RESP with fault, cause 01; no bus cycle.
//    - Legal access: go to REQ.
//    - start while busy=1 is ignored.
//  - REQ:
//    - mem_valid=1; mem_addr and mem_rstrb are stable until the cycle mem_ready is seen.
//    - mem_ready=1: capture mem_rdata, go to RESP; mem_valid=0 the next cycle.
//    - Else the counter increments; at TIMEOUT_CYCLES-1 go to RESP with fault, cause 11.
//  - RESP:
//    - done=1 for exactly one cycle; result_data/fault/fault_cause are valid with done.
//    - Then IDLE. A start in the RESP cycle is ignored.
//  - Latency: start@t, mem_valid@t+1, mem_ready@t+1 gives done@t+2. Minimum 2 cycles.
//  - Extraction: byte = rdata >> (8*a[1:0]); half = rdata >> (16*a[1]).
//    - LB/LH: sign-extend from bit 7/15. LBU/LHU: zero-extend. LW: unchanged.
//  - amo_operation_load=1: LW is used regardless of funct3; the illegal-funct3 check is skipped.
//  - mem_ready while not in REQ is ignored.
//  - The counter clears on every entry to REQ.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    - LH/LHU with a[0]=1, or LW/AMO with a[1:0]!=0: go IDLE->RESP with fault, cause 10.
//    - No bus request is issued.
//  MISALIGN_TRAP_EN undefined:
//    - The ignored low address bits are treated as 0 (LH uses a[1] only; LW uses the full word).
//    - No misaligned fault is ever raised; cause 10 is never produced.
// TESTING
//  - LB @0x1003, rdata=0x80FF_0000, ready in 1st REQ cycle -> done@t+2, result=0xFFFF_FF80, rstrb=1000.
//  - LHU @0x2002, rdata=0x9ABC_1234 -> result=0x0000_9ABC, rstrb=1100.
//  - LH @0x2002, rdata=0x9ABC_1234 -> result=0xFFFF_9ABC, rstrb=1100.
//  - LW, mem_ready withheld -> fault=1, cause=11 on done after TIMEOUT_CYCLES REQ cycles.
//  - LW, mem_ready withheld -> mem_valid low from the done cycle on.
//  - funct3=111 -> done@t+1, fault, cause=01, mem_valid never asserted.
//  - funct3=111 with amo_operation_load=1 @0x0 -> normal LW completes.
//  - LW @0x0006:
//    - With MISALIGN_TRAP_EN: fault, cause=10, no mem_valid.
//    - Without: mem_addr=0x4, result=rdata.
//  - resetn low while in REQ -> mem_valid=0 at once, no done.
//  - After release, a new LBU @0x3 completes normally.

Source files
------------

// File: rtl/load_access_unit.sv
// Load access unit: one word-aligned read on the native bus, then lane extraction and sign/zero extension.
// Optional feature macro MISALIGN_TRAP_EN: trap misaligned LH/LHU/LW/AMO accesses instead of masking low address bits.
module load_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic        amo_operation_load,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] result_data,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       addr_reg, addr_next;
  logic [1:0]        size_reg, size_next;
  logic              uns_reg, uns_next;
  logic [3:0]        rstrb_reg, rstrb_next;
  logic              fault_reg, fault_next;
  logic [1:0]        cause_reg, cause_next;
  logic [31:0]       result_reg, result_next;

  logic [2:0]  eff_f3;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  rstrb_dec;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] ext_data;

  // An AMO always behaves as a word load, so funct3 is not even checked for legality.
  assign eff_f3  = amo_operation_load ? 3'b010 : funct3;
  assign illegal = !amo_operation_load && ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((eff_f3[1:0] == 2'b01) && addr[0]) ||
                      ((eff_f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    rstrb_dec = 4'b1111;
    case (eff_f3[1:0])
      2'b00:   rstrb_dec = 4'b0001 << addr[1:0];
      2'b01:   rstrb_dec = 4'b0011 << {addr[1], 1'b0};
      default: rstrb_dec = 4'b1111;
    endcase
  end

  always_comb begin
    lane8 = mem_rdata[7:0];
    case (addr_reg[1:0])
      2'b00: lane8 = mem_rdata[7:0];
      2'b01: lane8 = mem_rdata[15:8];
      2'b10: lane8 = mem_rdata[23:16];
      2'b11: lane8 = mem_rdata[31:24];
    endcase
    lane16 = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_reg)
      2'b00:   ext_data = {{24{~uns_reg & lane8[7]}}, lane8};
      2'b01:   ext_data = {{16{~uns_reg & lane16[15]}}, lane16};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    size_next   = size_reg;
    uns_next    = uns_reg;
    rstrb_next  = rstrb_reg;
    fault_next  = fault_reg;
    cause_next  = cause_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next   = addr;
          size_next   = eff_f3[1:0];
          uns_next    = eff_f3[2];
          rstrb_next  = rstrb_dec;
          result_next = 32'd0;
          fault_next  = 1'b0;
          cause_next  = 2'b00;
          cnt_next    = '0;
          if (illegal) begin
            state_next = RESP;
            fault_next = 1'b1;
            cause_next = 2'b01;
          end else if (misaligned) begin
            state_next = RESP;
            fault_next = 1'b1;
            cause_next = 2'b10;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // A response arriving in the last allowed cycle still wins over the timeout.
        if (mem_ready) begin
          result_next = ext_data;
          state_next  = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          fault_next = 1'b1;
          cause_next = 2'b11;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= 32'd0;
      size_reg   <= 2'b00;
      uns_reg    <= 1'b0;
      rstrb_reg  <= 4'b0000;
      fault_reg  <= 1'b0;
      cause_reg  <= 2'b00;
      result_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      size_reg   <= size_next;
      uns_reg    <= uns_next;
      rstrb_reg  <= rstrb_next;
      fault_reg  <= fault_next;
      cause_reg  <= cause_next;
      result_reg <= result_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == RESP);
  assign mem_valid   = (state_reg == REQ);
  assign mem_addr    = {addr_reg[31:2], 2'b00};
  assign mem_rstrb   = rstrb_reg;
  assign fault       = fault_reg;
  assign fault_cause = cause_reg;
  assign result_data = result_reg;

endmodule

// File: tb/tb_load_access_unit.sv
// Directed bench for load_access_unit: hand-computed vectors checked with immediate assertions.
module tb_load_access_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic        amo_operation_load = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        busy, done, fault;
  logic [1:0]  fault_cause;
  logic [31:0] result_data;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  load_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
    .amo_operation_load(amo_operation_load), .addr(addr),
    .busy(busy), .done(done), .fault(fault), .fault_cause(fault_cause),
    .result_data(result_data), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_rstrb(mem_rstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns #1 after the accepting edge.
  task automatic start_load(input logic [2:0] f3, input logic amo, input logic [31:0] a);
    funct3 = f3;
    amo_operation_load = amo;
    addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    amo_operation_load = 1'b0;
  endtask

  // Return data in the current REQ cycle and check the completion that follows.
  task automatic respond(input string tag, input logic [31:0] rdata, input logic [31:0] exp);
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'hxxxx_xxxx;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_result"}, result_data, exp);
    chk({tag, "_valid_off"}, {31'd0, mem_valid}, 32'd0);
    tick();
    chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    chk({tag, "_held"}, result_data, exp);
    $display("txn %s: result=%h", tag, result_data);
  endtask

  initial begin
    int n;
    logic got_done;

    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_cause", {30'd0, fault_cause}, 32'd0);
    chk("rst_result", result_data, 32'd0);
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rstrb", {28'd0, mem_rstrb}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // LB @0x1003
    start_load(3'b000, 1'b0, 32'h0000_1003);
    chk("lb_valid", {31'd0, mem_valid}, 32'd1);
    chk("lb_busy", {31'd0, busy}, 32'd1);
    chk("lb_addr", mem_addr, 32'h0000_1000);
    chk("lb_rstrb", {28'd0, mem_rstrb}, 32'h8);
    respond("lb", 32'h80FF_0000, 32'hFFFF_FF80);

    // LHU @0x2002
    start_load(3'b101, 1'b0, 32'h0000_2002);
    chk("lhu_rstrb", {28'd0, mem_rstrb}, 32'hC);
    chk("lhu_addr", mem_addr, 32'h0000_2000);
    respond("lhu", 32'h9ABC_1234, 32'h0000_9ABC);

    // LH @0x2002
    start_load(3'b001, 1'b0, 32'h0000_2002);
    chk("lh_rstrb", {28'd0, mem_rstrb}, 32'hC);
    respond("lh", 32'h9ABC_1234, 32'hFFFF_9ABC);

    // LB / LBU on byte lane 1
    start_load(3'b000, 1'b0, 32'h0000_1001);
    chk("lb1_rstrb", {28'd0, mem_rstrb}, 32'h2);
    respond("lb1", 32'h1234_85F0, 32'hFFFF_FF85);
    start_load(3'b100, 1'b0, 32'h0000_1001);
    respond("lbu1", 32'h1234_85F0, 32'h0000_0085);

    // LH on the low half, positive value
    start_load(3'b001, 1'b0, 32'h0000_2000);
    chk("lhlo_rstrb", {28'd0, mem_rstrb}, 32'h3);
    respond("lhlo", 32'h9ABC_7234, 32'h0000_7234);

    // LW timeout, with a stray start mid-request
    start_load(3'b010, 1'b0, 32'h0000_0010);
    chk("to_rstrb", {28'd0, mem_rstrb}, 32'hF);
    n = 0;
    got_done = 1'b0;
    for (int i = 0; i < int'(TO) + 8; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (mem_valid) n++;
      start  = (i == 3);
      funct3 = (i == 3) ? 3'b111 : 3'b010;
      tick();
    end
    start = 1'b0;
    chk("to_done", {31'd0, got_done}, 32'd1);
    chk("to_req_cycles", n, TO);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_cause", {30'd0, fault_cause}, 32'd3);
    chk("to_result", result_data, 32'd0);
    chk("to_valid_off", {31'd0, mem_valid}, 32'd0);
    tick();
    chk("to_valid_after", {31'd0, mem_valid}, 32'd0);
    chk("to_idle", {31'd0, busy}, 32'd0);
    $display("txn timeout: req_cycles=%0d cause=%0d", n, fault_cause);

    // Illegal funct3, plus a start during the RESP cycle that must be dropped
    start_load(3'b111, 1'b0, 32'h0000_0040);
    chk("ill_done", {31'd0, done}, 32'd1);
    chk("ill_fault", {31'd0, fault}, 32'd1);
    chk("ill_cause", {30'd0, fault_cause}, 32'd1);
    chk("ill_result", result_data, 32'd0);
    chk("ill_valid", {31'd0, mem_valid}, 32'd0);
    funct3 = 3'b010;
    addr = 32'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ill_resp_start_ignored", {31'd0, busy}, 32'd0);
    chk("ill_valid_after", {31'd0, mem_valid}, 32'd0);
    $display("txn illegal: cause=%0d", fault_cause);

    // funct3=111 with AMO forces LW
    start_load(3'b111, 1'b1, 32'h0000_0000);
    chk("amo_valid", {31'd0, mem_valid}, 32'd1);
    chk("amo_rstrb", {28'd0, mem_rstrb}, 32'hF);
    respond("amo", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

`ifdef MISALIGN_TRAP_EN
    start_load(3'b010, 1'b0, 32'h0000_0006);
    chk("lwmis_done", {31'd0, done}, 32'd1);
    chk("lwmis_fault", {31'd0, fault}, 32'd1);
    chk("lwmis_cause", {30'd0, fault_cause}, 32'd2);
    chk("lwmis_valid", {31'd0, mem_valid}, 32'd0);
    tick();
    start_load(3'b001, 1'b0, 32'h0000_2003);
    chk("lhmis_cause", {30'd0, fault_cause}, 32'd2);
    chk("lhmis_valid", {31'd0, mem_valid}, 32'd0);
    tick();
    $display("txn misaligned: trapped");
`else
    start_load(3'b010, 1'b0, 32'h0000_0006);
    chk("lwmis_valid", {31'd0, mem_valid}, 32'd1);
    chk("lwmis_addr", mem_addr, 32'h0000_0004);
    chk("lwmis_rstrb", {28'd0, mem_rstrb}, 32'hF);
    respond("lwmis", 32'hCAFE_F00D, 32'hCAFE_F00D);
    start_load(3'b001, 1'b0, 32'h0000_2003);
    chk("lhmis_rstrb", {28'd0, mem_rstrb}, 32'hC);
    respond("lhmis", 32'h9ABC_1234, 32'hFFFF_9ABC);
`endif

    // mem_ready while idle is ignored
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    chk("idle_ready_done", {31'd0, done}, 32'd0);
    chk("idle_ready_busy", {31'd0, busy}, 32'd0);

    // Async reset in REQ
    start_load(3'b010, 1'b0, 32'h0000_0008);
    chk("rreq_valid", {31'd0, mem_valid}, 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    chk("rreq_valid_drop", {31'd0, mem_valid}, 32'd0);
    chk("rreq_busy", {31'd0, busy}, 32'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    tick();
    tick();
    resetn = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rreq_no_done", {31'd0, done}, 32'd0);
      tick();
    end
    $display("txn reset_in_req: mem_valid=%0d done=%0d", mem_valid, done);

    // LBU @0x3 after reset
    start_load(3'b100, 1'b0, 32'h0000_0003);
    chk("lbu3_rstrb", {28'd0, mem_rstrb}, 32'h8);
    chk("lbu3_addr", mem_addr, 32'h0000_0000);
    respond("lbu3", 32'hA500_0000, 32'h0000_00A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
